// File: rtl/timer_seq_ctrl.sv
// ----------------------------------------------------------------------------
// timer_seq_ctrl
//
// Sequences an external 4-bit synchronous loadable counter (163-style: load
// active-low with priority over count, count when T and P are both high) to
// time one-shot or periodic runs. A period is the span from the counter
// holding P until it reaches 4'hF, i.e. 16-P enabled cycles.
//
// Request/pulse protocol: start is a single-cycle request that is only
// accepted in IDLE with stop low, and it is ignored at any other time. stop
// aborts a run in LOAD or RUN and always wins over start. tick and done are
// single-cycle pulses with no acknowledge; the consumer must sample them on
// the cycle they are high.
//
// Ports
//   CP, CR        clock; synchronous active-high reset
//   start, stop   run request / abort request
//   hold          freeze the counter while high
//   mode          0 = one-shot, 1 = periodic
//   preset        counter load value P
//   reps          periodic run length R (0 = run until stop)
//   Q_i, CO_i     counter state and terminal count (Q_i == 4'hF)
//   LDn_o, D_o    counter load strobe (active-low) and load data
//   CTT_o, CTP_o  counter enables T and P
//   busy          controller is not idle
//   tick          one pulse per completed period
//   done          one pulse when a run completes normally
//   pcnt          completed periods of the current/last run
//   o_dbg_state   current FSM state (debug)
//   o_dbg_q       counter state as seen by the controller (debug/status)
// ----------------------------------------------------------------------------
module timer_seq_ctrl (
    input  logic       CP,
    input  logic       CR,
    input  logic       start,
    input  logic       stop,
    input  logic       hold,
    input  logic       mode,
    input  logic [3:0] preset,
    input  logic [3:0] reps,
    input  logic [3:0] Q_i,
    input  logic       CO_i,
    output logic       LDn_o,
    output logic [3:0] D_o,
    output logic       CTT_o,
    output logic       CTP_o,
    output logic       busy,
    output logic       tick,
    output logic       done,
    output logic [3:0] pcnt,
    output logic [1:0] o_dbg_state,
    output logic [3:0] o_dbg_q
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_preset;
    logic [3:0] r_reps;
    logic       r_mode;
    logic [3:0] r_pcnt;
    logic       r_tick;

    state_t     w_next;
    logic       w_ldn;
    logic       w_ctt;
    logic       w_ctp;
    logic       w_accept;
    logic       w_period_end;
    logic       w_final;
    logic [3:0] w_pcnt_inc;

    assign w_accept     = start & ~stop;
    // CO_i seen while held is not a period end; the end is taken on the
    // first cycle hold is released, so the period stretches by the hold time.
    assign w_period_end = (r_state == S_RUN) & CO_i & ~hold & ~stop;
    assign w_pcnt_inc   = r_pcnt + 4'd1;
    // Continuous runs (periodic with R=0) never reach a final period, and
    // pcnt simply wraps through 4 bits.
    assign w_final      = ~r_mode | ((r_reps != 4'd0) & (w_pcnt_inc == r_reps));

    // State register and run bookkeeping.
    always_ff @(posedge CP) begin
        if (CR) begin
            r_state  <= S_IDLE;
            r_preset <= 4'd0;
            r_reps   <= 4'd0;
            r_mode   <= 1'b0;
            r_pcnt   <= 4'd0;
            r_tick   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tick  <= w_period_end;
            if ((r_state == S_IDLE) && w_accept) begin
                r_preset <= preset;
                r_reps   <= reps;
                r_mode   <= mode;
                r_pcnt   <= 4'd0;
            end else if (w_period_end) begin
                r_pcnt <= w_pcnt_inc;
            end
        end
    end

    // Next state and counter controls.
    always_comb begin
        w_next = r_state;
        w_ldn  = 1'b1;
        w_ctt  = 1'b0;
        w_ctp  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (stop) begin
                    w_next = S_IDLE;
                end else begin
                    w_ldn  = 1'b0;
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_next = S_IDLE;
                end else begin
                    w_ctt = 1'b1;
                    w_ctp = ~hold;
                    if (w_period_end) begin
                        if (w_final) begin
                            // Drop T so the counter parks at 4'hF.
                            w_ctt  = 1'b0;
                            w_next = S_DONE;
                        end else begin
                            // Reload P in place of the 15->0 wrap.
                            w_ldn = 1'b0;
                        end
                    end
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign LDn_o       = w_ldn;
    assign D_o         = r_preset;
    assign CTT_o       = w_ctt;
    assign CTP_o       = w_ctp;
    assign busy        = (r_state != S_IDLE);
    assign tick        = r_tick;
    assign done        = (r_state == S_DONE);
    assign pcnt        = r_pcnt;
    assign o_dbg_state = r_state;
    assign o_dbg_q     = Q_i;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_timer_seq_ctrl
//
// Drives timer_seq_ctrl against a behavioural 163-style counter. Each
// directed run pushes its expected tick/done events (flags, pcnt, counter
// value, cycle offset from the start request) into exp_q; the monitor pops
// one entry whenever tick or done is seen and compares. Inputs are driven
// 1 time unit after the rising edge; everything is sampled on the falling
// edge.
// ----------------------------------------------------------------------------
module tb_timer_seq_ctrl;

    logic       CP;
    logic       CR;
    logic       start;
    logic       stop;
    logic       hold;
    logic       mode;
    logic [3:0] preset;
    logic [3:0] reps;
    logic [3:0] q_cnt = 4'h0;
    logic       co;
    logic       LDn_o;
    logic [3:0] D_o;
    logic       CTT_o;
    logic       CTP_o;
    logic       busy;
    logic       tick;
    logic       done;
    logic [3:0] pcnt;
    logic [1:0] dbg_state;
    logic [3:0] dbg_q;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int base     = 0;

    // {tick, done, pcnt, q, cycle offset}
    logic [17:0] exp_q[$];
    logic [17:0] mon_act;
    logic [17:0] mon_exp;

    timer_seq_ctrl dut (
        .CP          (CP),
        .CR          (CR),
        .start       (start),
        .stop        (stop),
        .hold        (hold),
        .mode        (mode),
        .preset      (preset),
        .reps        (reps),
        .Q_i         (q_cnt),
        .CO_i        (co),
        .LDn_o       (LDn_o),
        .D_o         (D_o),
        .CTT_o       (CTT_o),
        .CTP_o       (CTP_o),
        .busy        (busy),
        .tick        (tick),
        .done        (done),
        .pcnt        (pcnt),
        .o_dbg_state (dbg_state),
        .o_dbg_q     (dbg_q)
    );

    // ---------------- clock / counter model ----------------
    initial CP = 1'b0;
    always #5 CP = ~CP;

    always @(posedge CP) cyc <= cyc + 1;

    always @(posedge CP) begin
        if (!LDn_o)
            q_cnt <= D_o;
        else if (CTT_o && CTP_o)
            q_cnt <= q_cnt + 4'd1;
    end
    assign co = (q_cnt == 4'hF);

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [17:0] ev(input logic t, input logic d, input logic [3:0] pc,
                                       input logic [3:0] qv, input logic [7:0] rel);
        return {t, d, pc, qv, rel};
    endfunction

    task automatic do_start(input logic [3:0] p, input logic [3:0] r, input logic m);
        @(posedge CP); #1;
        preset = p; reps = r; mode = m; start = 1'b1;
        base = cyc;
        @(posedge CP); #1;
        start = 1'b0;
    endtask

    // Advance to 1 unit after the edge that begins cycle offset r.
    task automatic wait_rel(input int r);
        while ((cyc - base) < r) begin
            @(posedge CP); #1;
        end
    endtask

    task automatic at_neg();
        @(negedge CP);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge CP) begin
        if (!CR && (tick || done)) begin
            mon_act = {tick, done, pcnt, q_cnt, 8'(cyc - base)};
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: got %h expected none (t=%0t)", mon_act, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("event", 32'(mon_act), 32'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        CR = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; mode = 1'b0;
        preset = 4'h0; reps = 4'h0;

        // Reset values
        repeat (3) @(posedge CP);
        at_neg();
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_ldn",   32'(LDn_o),     32'd1);
        chk("rst_d",     32'(D_o),       32'd0);
        chk("rst_ctt",   32'(CTT_o),     32'd0);
        chk("rst_ctp",   32'(CTP_o),     32'd0);
        chk("rst_pulse", 32'({tick, done}), 32'd0);
        chk("rst_pcnt",  32'(pcnt),      32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        @(posedge CP); #1;
        CR = 1'b0;

        // A: one-shot P=C -> LOAD, RUN C..F, tick+done at offset 6
        exp_q.push_back(ev(1'b1, 1'b1, 4'd1, 4'hF, 8'd6));
        do_start(4'hC, 4'h0, 1'b0);
        at_neg();
        chk("a_load_ldn", 32'(LDn_o), 32'd0);
        chk("a_load_d",   32'(D_o),   32'hC);
        chk("a_load_ctt", 32'(CTT_o), 32'd0);
        chk("a_busy",     32'(busy),  32'd1);
        wait_rel(2); at_neg();
        chk("a_run_en",   32'({CTT_o, CTP_o}), 32'b11);
        chk("a_run_q",    32'(q_cnt), 32'hC);
        wait_rel(8); at_neg();
        chk("a_drain",    32'(exp_q.size()), 32'd0);
        chk("a_idle",     32'(busy),  32'd0);
        chk("a_pcnt",     32'(pcnt),  32'd1);
        chk("a_q_hold",   32'(q_cnt), 32'hF);

        // B: periodic P=E R=3 -> ticks at 4,6,8, done with the third
        exp_q.push_back(ev(1'b1, 1'b0, 4'd1, 4'hE, 8'd4));
        exp_q.push_back(ev(1'b1, 1'b0, 4'd2, 4'hE, 8'd6));
        exp_q.push_back(ev(1'b1, 1'b1, 4'd3, 4'hF, 8'd8));
        do_start(4'hE, 4'd3, 1'b1);
        wait_rel(3); at_neg();
        chk("b_reload_ldn", 32'(LDn_o), 32'd0);
        chk("b_reload_d",   32'(D_o),   32'hE);
        wait_rel(10); at_neg();
        chk("b_drain", 32'(exp_q.size()), 32'd0);
        chk("b_pcnt",  32'(pcnt), 32'd3);
        chk("b_idle",  32'(busy), 32'd0);

        // C: continuous P=F -> tick every cycle, pcnt wraps, stop after 17
        for (int k = 1; k <= 17; k++)
            exp_q.push_back(ev(1'b1, 1'b0, 4'(k % 16), 4'hF, 8'(k + 2)));
        do_start(4'hF, 4'd0, 1'b1);
        wait_rel(19);
        stop = 1'b1;
        wait_rel(20);
        stop = 1'b0;
        at_neg();
        chk("c_stop_idle", 32'(busy), 32'd0);
        chk("c_pcnt_wrap", 32'(pcnt), 32'd1);
        chk("c_no_done",   32'(done), 32'd0);
        wait_rel(23); at_neg();
        chk("c_drain", 32'(exp_q.size()), 32'd0);

        // D: one-shot P=E, hold for 3 cycles while at F -> end stretched by 3
        exp_q.push_back(ev(1'b1, 1'b1, 4'd1, 4'hF, 8'd7));
        do_start(4'hE, 4'd0, 1'b0);
        wait_rel(3);
        hold = 1'b1;
        at_neg();
        chk("d_hold_ctp", 32'(CTP_o), 32'd0);
        wait_rel(6);
        hold = 1'b0;
        wait_rel(9); at_neg();
        chk("d_drain", 32'(exp_q.size()), 32'd0);
        chk("d_q",     32'(q_cnt), 32'hF);

        // E: start+stop together in IDLE is refused
        @(posedge CP); #1;
        start = 1'b1; stop = 1'b1; preset = 4'h3;
        @(posedge CP); #1;
        start = 1'b0; stop = 1'b0;
        at_neg();
        chk("e_refused_busy",  32'(busy),      32'd0);
        chk("e_refused_state", 32'(dbg_state), 32'd0);

        // E: start with a new preset mid-run is ignored
        exp_q.push_back(ev(1'b1, 1'b0, 4'd1, 4'hE, 8'd4));
        exp_q.push_back(ev(1'b1, 1'b1, 4'd2, 4'hF, 8'd6));
        do_start(4'hE, 4'd2, 1'b1);
        wait_rel(3);
        start = 1'b1; preset = 4'h0; mode = 1'b0; reps = 4'd5;
        wait_rel(4);
        start = 1'b0;
        at_neg();
        chk("e_latched_d", 32'(D_o), 32'hE);
        wait_rel(8); at_neg();
        chk("e_drain", 32'(exp_q.size()), 32'd0);
        chk("e_pcnt",  32'(pcnt), 32'd2);

        // stop during LOAD: back to IDLE, no load, no events
        do_start(4'hC, 4'd0, 1'b0);
        stop = 1'b1;
        at_neg();
        chk("s_load_ldn", 32'(LDn_o), 32'd1);
        wait_rel(2);
        stop = 1'b0;
        at_neg();
        chk("s_idle", 32'(busy),  32'd0);
        chk("s_pcnt", 32'(pcnt),  32'd0);
        chk("s_q",    32'(q_cnt), 32'hF);
        wait_rel(6); at_neg();
        chk("s_drain", 32'(exp_q.size()), 32'd0);

        // F: CR during RUN at Q=D -> IDLE with reset outputs, no done
        do_start(4'hC, 4'd0, 1'b0);
        wait_rel(3); at_neg();
        chk("f_q_d", 32'(q_cnt), 32'hD);
        CR = 1'b1;
        wait_rel(4);
        CR = 1'b0;
        at_neg();
        chk("f_busy",  32'(busy),  32'd0);
        chk("f_ldn",   32'(LDn_o), 32'd1);
        chk("f_d",     32'(D_o),   32'd0);
        chk("f_en",    32'({CTT_o, CTP_o}), 32'd0);
        chk("f_pulse", 32'({tick, done}),   32'd0);
        chk("f_pcnt",  32'(pcnt),  32'd0);
        wait_rel(9); at_neg();
        chk("f_drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
